// File: rtl/counter_sequencer.sv
// Run-control sequencer for the lab counter: start/pause/resume/clear on an up/down count
// with a clock-enable prescaler tick. Optional macro: COUNTER_SEQ_AUTORELOAD_EN (reload at terminal).
module counter_sequencer #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 6_250_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_clear,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic [1:0]       state
);

    // state    | meaning
    // IDLE  00 | cleared, waiting for start
    // RUN   01 | prescaler running, count advances on each tick
    // PAUSE 10 | stopped mid-run, count and prescaler frozen
    // DONE  11 | terminal reached (no autoreload), count held
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             dir_q, dir_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             btn_start_q, btn_stop_q, btn_clear_q;

    logic             start_p, stop_p, clear_p;
    logic             tick;
    logic [WIDTH-1:0] term;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    logic             reload_pulse;
`endif

    always_comb begin
        start_p = btn_start & ~btn_start_q;
        stop_p  = btn_stop  & ~btn_stop_q;
        clear_p = btn_clear & ~btn_clear_q;
        tick    = (presc_q == PRESC_MAX);
        term    = dir_q ? limit_q : '0;

        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        limit_d = limit_q;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        reload_pulse = 1'b0;
`endif

        if (clear_p) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (stop_p && state_q == ST_RUN) begin
            state_d = ST_PAUSE;
        end else if (start_p && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            dir_d   = dir;
            limit_d = limit;
            count_d = dir ? '0 : limit;
            presc_d = '0;
            state_d = ST_RUN;
        end else if (start_p && state_q == ST_PAUSE) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                presc_d = '0;
                if (count_q == term) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                    count_d      = dir_q ? '0 : limit_q;
                    reload_pulse = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        running_d = (state_d == ST_RUN);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        done_d = reload_pulse;
`else
        done_d = (state_d == ST_DONE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            presc_q     <= '0;
            dir_q       <= 1'b1;
            limit_q     <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            btn_start_q <= 1'b0;
            btn_stop_q  <= 1'b0;
            btn_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            dir_q       <= dir_d;
            limit_q     <= limit_d;
            running_q   <= running_d;
            done_q      <= done_d;
            btn_start_q <= btn_start;
            btn_stop_q  <= btn_stop;
            btn_clear_q <= btn_clear;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed scenarios plus random button traffic,
// checked against a cycle-level behavioural model of the run-control rules.
module tb_counter_sequencer;
    localparam int WIDTH    = 16;
    localparam int TICK_DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
    logic             dir = 1'b1;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] count;
    logic             running, done;
    logic [1:0]       state;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
        .dir(dir), .limit(limit),
        .count(count), .running(running), .done(done), .state(state)
    );

    typedef struct {
        logic [WIDTH-1:0] count;
        logic [1:0]       state;
        logic             running;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: clocks elapsed in the current tick period, run direction/limit captured at start.
    int m_state = M_IDLE, m_count = 0, m_elapsed = 0, m_dir = 1, m_limit = 0;
    bit m_prev_s = 0, m_prev_p = 0, m_prev_c = 0;

    bit   cur_dir = 1'b1;
    int   cur_limit = 0;

    task automatic model_edge(input bit s, input bit p, input bit c, input bit rst_n,
                              input bit d, input int l);
        bit   ps, pp, pc, pulse;
        int   target;
        exp_t e;
        pulse = 0;
        if (!rst_n) begin
            m_state = M_IDLE; m_count = 0; m_elapsed = 0; m_dir = 1; m_limit = 0;
            m_prev_s = 0; m_prev_p = 0; m_prev_c = 0;
        end else begin
            ps = s && !m_prev_s;
            pp = p && !m_prev_p;
            pc = c && !m_prev_c;
            m_prev_s = s; m_prev_p = p; m_prev_c = c;
            if (pc) begin
                m_state = M_IDLE; m_count = 0; m_elapsed = 0;
            end else if (pp && m_state == M_RUN) begin
                m_state = M_PAUSE;
            end else if (ps && (m_state == M_IDLE || m_state == M_DONE)) begin
                m_dir = d; m_limit = l; m_count = d ? 0 : l; m_elapsed = 0; m_state = M_RUN;
            end else if (ps && m_state == M_PAUSE) begin
                m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                m_elapsed++;
                if (m_elapsed == TICK_DIV) begin
                    m_elapsed = 0;
                    target = m_dir ? m_limit : 0;
                    if (m_count == target) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                        m_count = m_dir ? 0 : m_limit;
                        pulse = 1;
`else
                        m_state = M_DONE;
`endif
                    end else begin
                        m_count = m_dir ? (m_count + 1) % (1 << WIDTH) : m_count - 1;
                    end
                end
            end
        end
        e.count   = m_count[WIDTH-1:0];
        e.state   = m_state[1:0];
        e.running = (m_state == M_RUN);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        e.done    = pulse;
`else
        e.done    = (m_state == M_DONE);
`endif
        exp_q.push_back(e);
    endtask

    task automatic step(input bit s, input bit p, input bit c, input bit rst_n);
        @(negedge clk);
        btn_start = s; btn_stop = p; btn_clear = c; reset = rst_n;
        dir = cur_dir; limit = cur_limit[WIDTH-1:0];
        @(posedge clk);
        model_edge(s, p, c, rst_n, cur_dir, cur_limit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic press_start();
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic press_stop();
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic press_clear();
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count",   int'(count),   int'(e.count));
            chk("state",   int'(state),   int'(e.state));
            chk("running", int'(running), int'(e.running));
            chk("done",    int'(done),    int'(e.done));
        end
    end

    initial begin
        bit s, p, c, r;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        idle(2);

        // up to 3, then DONE, held until clear
        cur_dir = 1; cur_limit = 3;
        press_start();
        idle(25);
        press_clear();

        // down from 2, pause at 1, resume completes the partial period
        cur_dir = 0; cur_limit = 2;
        step(1, 0, 0, 1);
        idle(4);
        step(0, 1, 0, 1);
        idle(20);
        step(1, 0, 0, 1);
        idle(15);
        press_clear();

        // start+stop+clear together mid-run
        cur_dir = 1; cur_limit = 20;
        step(1, 0, 0, 1);
        idle(29);
        step(1, 1, 1, 1);
        idle(3);

        // reset mid-run near count 5
        cur_dir = 1; cur_limit = 10;
        step(1, 0, 0, 1);
        idle(21);
        step(0, 0, 0, 0);
        idle(3);

        // held start gives one press; limit change mid-run is ignored
        cur_dir = 1; cur_limit = 12;
        for (int i = 0; i < 50; i++) begin
            if (i == 5) cur_limit = 9;
            step(1, 0, 0, 1);
        end
        step(0, 0, 0, 1);
        press_stop();
        idle(6);
        press_start();
        idle(30);
        press_clear();

        // limit 0 in both directions
        cur_dir = 1; cur_limit = 0;
        press_start();
        idle(8);
        cur_dir = 0;
        press_start();
        idle(8);
        press_clear();

        // button held across reset registers one press after release
        cur_dir = 1; cur_limit = 2;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        idle(14);
        press_clear();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 9) == 0) cur_dir = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0)
                cur_limit = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 65535)
                                                         : $urandom_range(0, 6);
            step(s, p, c, r);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run-control state machine for the lab counter datapath. Turns debounced start/stop/clear buttons into start, pause, resume and clear operations on a WIDTH-bit up/down count. It generates its own count tick from the system clock through a clock-enable prescaler, so it needs no divided clock. It stops or reloads at a programmable limit. Its `count` output feeds the LEDs and the 7-segment driver.

## Interface

Parameters:
- `WIDTH`, 16: count and limit width.
- `TICK_DIV`, 6_250_000: system clocks per count tick. At 100 MHz this gives 16 Hz. Must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `btn_start`  input  1  debounced level, synchronous to `clk`.
- `btn_stop`  input  1  debounced level.
- `btn_clear`  input  1  debounced level.
- `dir`  input  1  count direction: 1 = up, 0 = down. Sampled only on a start from IDLE or DONE.
- `limit`  input  WIDTH  terminal value. Sampled only on a start from IDLE or DONE.
- `count`  output  WIDTH  current count, registered.
- `running`  output  1  high while the state is RUN.
- `done`  output  1  terminal-count indication.
- `state`  output  2  encodings: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation

- Press detection:
  - Each button input is registered. A press is `btn & ~btn_q`.
  - Holding a button produces exactly one press.
- Press priority in the same cycle: clear > stop > start.
- Clear, in any state:
  - state → IDLE, `count` ← 0, prescaler ← 0, `done` ← 0.
- Start:
  - From IDLE or DONE:
    - latch `dir_q` ← `dir` and `limit_q` ← `limit`;
    - `count` ← 0 if up, `limit` if down;
    - prescaler ← 0; state → RUN.
  - From PAUSE: state → RUN. `count`, prescaler, `dir_q` and `limit_q` are unchanged (resume).
  - In RUN: ignored.
- Stop:
  - In RUN: state → PAUSE and the prescaler freezes.
  - In other states: ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
  - `tick` is asserted when the prescaler equals TICK_DIV-1.
- Count on a tick in RUN:
  - If `count` ≠ terminal value: count +1 when up, −1 when down.
  - Terminal value is `limit_q` when up, 0 when down.
  - If `count` = terminal value on a tick: see Configuration. Without autoreload, state → DONE and `count` holds.
- Limit 0: an up or down run enters DONE at the first tick.
- Arithmetic is modulo 2^WIDTH. With a terminal compare, the count never passes terminal, so no wrap-around occurs in normal operation.
- `running` = (state == RUN). `done` = (state == DONE) when autoreload is compiled out.

## Timing

- All outputs are registered.
- A press sampled at edge N takes effect at that edge. `state` and `count` show the new value from edge N onward, i.e. one cycle after the button level first reads high.
- The first tick after a start arrives TICK_DIV clocks later. The counting period is exactly TICK_DIV clocks.
- Resume from PAUSE continues the partially elapsed tick period.
- The terminal value is held for one full tick period before DONE/reload.
- Reset (`reset` = 0 at an edge) overrides all inputs, including mid-run:
  - state = IDLE, `count` = 0, prescaler = 0, `running` = 0, `done` = 0;
  - `dir_q` = 1, `limit_q` = 0;
  - button registers = 0, so a button held through reset registers one press after release of reset.

## Configuration

- `COUNTER_SEQ_AUTORELOAD_EN`:
  - Defined: a tick at terminal reloads the start value (0 up, `limit_q` down) and the state stays RUN. `done` is a one-cycle pulse coincident with the reload. DONE is unreachable.
  - Undefined: a tick at terminal enters DONE. `done` is a level for as long as the state is DONE.

## Test plan

Bench uses TICK_DIV=4, WIDTH=16.

- Reset mid-run at count=5 → next cycle state=00, count=0, running=0, done=0.
- Start with dir=1, limit=3 (macro off) → count 0,1,2,3 every 4 clocks; 4 clocks after reaching 3, state=11 and done=1. count stays 3 until clear.
- Start with dir=0, limit=2; stop after first decrement (count=1); wait 20 clocks; start → count stays 1 while paused. Resume finishes the partial period, then 0, then DONE.
- Same cycle start+stop+clear during RUN at count=7 → state=IDLE, count=0.
- Macro on, dir=1, limit=2 → count 0,1,2,0,1… with a one-cycle done pulse on each 2→0 reload. running stays 1.
- Hold btn_start high for 50 clocks from IDLE, then press stop → single start (no restart); limit changed mid-run to 9 has no effect on terminal.
